// File: rtl/comparator_pkg.sv
// Shared types and result encodings for the
// serial magnitude comparator controller.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

endpackage

// File: rtl/comparator_serial_controller_slice.sv
// Combinational 2-bit unsigned magnitude compare slice.
// Outputs are forced low while Reset_In is high.
module Comparator_2_Bit (
  input  logic       Reset_In,
  input  logic [1:0] A_In,
  input  logic [1:0] B_In,
  output logic       A_Less_Than_B_Out,
  output logic       A_Equal_To_B_Out,
  output logic       A_Greater_Than_B_Out
);

  always_comb begin
    A_Less_Than_B_Out    = 1'b0;
    A_Equal_To_B_Out     = 1'b0;
    A_Greater_Than_B_Out = 1'b0;
    if (!Reset_In) begin
      A_Less_Than_B_Out    = (A_In < B_In);
      A_Equal_To_B_Out     = (A_In == B_In);
      A_Greater_Than_B_Out = (A_In > B_In);
    end
  end

endmodule

// File: rtl/comparator_serial_controller.sv
// Serial MSB-first magnitude comparator: walks 2-bit slices
// through one shared slice and stops on the first difference.
module comparator_serial_controller
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  A_Less_Than_B_Out,
  output logic                  A_Equal_To_B_Out,
  output logic                  A_Greater_Than_B_Out,
  output logic [$clog2(DATA_WIDTH/2):0] Compare_Count_Out
);

  localparam int NUM_SLICES = DATA_WIDTH / 2;
  localparam int CNT_WIDTH  = $clog2(NUM_SLICES) + 1;
  localparam int IDX_W =
    (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  generate
    if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 2) begin : g_bad
      $error("DATA_WIDTH must be even and >= 2");
    end
  endgenerate

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [2:0]            r_res;
  logic                  r_busy;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] w_a_sh;
  logic [DATA_WIDTH-1:0] w_b_sh;
  logic [1:0]            w_a_slice;
  logic [1:0]            w_b_slice;
  logic                  w_lt;
  logic                  w_eq;
  logic                  w_gt;

  assign w_a_sh    = r_a >> {r_idx, 1'b0};
  assign w_b_sh    = r_b >> {r_idx, 1'b0};
  assign w_a_slice = w_a_sh[1:0];
  assign w_b_slice = w_b_sh[1:0];

  Comparator_2_Bit u_slice (
    .Reset_In             (Reset_In),
    .A_In                 (w_a_slice),
    .B_In                 (w_b_slice),
    .A_Less_Than_B_Out    (w_lt),
    .A_Equal_To_B_Out     (w_eq),
    .A_Greater_Than_B_Out (w_gt)
  );

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (Start_In) begin
            r_a     <= Data_A_In;
            r_b     <= Data_B_In;
            r_idx   <= IDX_W'(NUM_SLICES - 1);
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b1;
            r_state <= COMPARE;
          end else begin
            r_state <= IDLE;
          end
        end
        COMPARE: begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (!w_eq) begin
            r_res   <= w_lt ? RES_LT : (w_gt ? RES_GT : 3'b000);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_idx == '0) begin
            r_res   <= RES_EQ;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Busy_Out             = r_busy;
  assign Done_Out             = r_done;
  assign A_Less_Than_B_Out    = r_res[2];
  assign A_Equal_To_B_Out     = r_res[1];
  assign A_Greater_Than_B_Out = r_res[0];
  assign Compare_Count_Out    = r_cnt;

endmodule

// File: tb/tb_comparator_serial_controller.sv
// Self-checking bench for the serial comparator controller:
// directed cases plus randomized compares against a model.
module tb_comparator_serial_controller;

  localparam int DW = 8;
  localparam int NS = DW / 2;
  localparam int CW = $clog2(NS) + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] da;
  logic [DW-1:0] db;
  logic          busy;
  logic          done;
  logic          lt;
  logic          eq;
  logic          gt;
  logic [CW-1:0] cnt;

  int checks;
  int errors;

  comparator_serial_controller #(.DATA_WIDTH(DW)) dut (
    .Clock_In             (clk),
    .Reset_In             (rst),
    .Start_In             (start),
    .Data_A_In            (da),
    .Data_B_In            (db),
    .Busy_Out             (busy),
    .Done_Out             (done),
    .A_Less_Than_B_Out    (lt),
    .A_Equal_To_B_Out     (eq),
    .A_Greater_Than_B_Out (gt),
    .Compare_Count_Out    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected slice count: position of first differing
  // 2-bit group from the MSB, or all groups if equal.
  function automatic int model_k(input logic [DW-1:0] a,
                                 input logic [DW-1:0] b);
    for (int i = 1; i <= NS; i++) begin
      if (((a >> (DW - 2 * i)) & 2'b11) !=
          ((b >> (DW - 2 * i)) & 2'b11))
        return i;
    end
    return NS;
  endfunction

  function automatic logic [2:0] model_res(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    if (a < b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_out"}, {busy, done, lt, eq, gt, 3'(cnt)}, 0);
  endtask

  // Called right after the edge that accepted Start.
  task automatic wait_done(input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
    int edges;
    chk("acc_busy", {busy, done}, 2'b10);
    chk("acc_clr", {lt, eq, gt, 3'(cnt)}, 0);
    edges = 0;
    while (!done && edges < 20) begin
      if (busy !== 1'b1) chk("busy_hold", busy, 1);
      tick();
      edges++;
    end
    if (!done) begin
      chk("timeout", 1, 0);
    end else begin
      chk("latency", edges, model_k(a, b));
      chk("result", {lt, eq, gt}, model_res(a, b));
      chk("count", cnt, model_k(a, b));
      chk("onehot", 32'(lt) + 32'(eq) + 32'(gt), 1);
      chk("no_busy", busy, 0);
    end
  endtask

  task automatic launch(input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    da = a;
    db = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    da = DW'($urandom);
    db = DW'($urandom);
    wait_done(a, b);
  endtask

  initial begin
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [2:0]    hold;
    logic [CW-1:0] hcnt;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    da = '0;
    db = '0;
    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();
    chk_idle_zero("idle1");
    tick();
    chk_idle_zero("idle2");

    launch(8'h80, 8'h40);
    tick();
    chk("done_pulse", done, 0);
    hold = {lt, eq, gt};
    hcnt = cnt;
    chk("held_res", hold, 3'b001);
    chk("held_cnt", hcnt, 1);

    launch(8'h12, 8'h13);
    launch(8'hB4, 8'hB4);

    // Start held, operands changed mid-compare.
    da = 8'h12;
    db = 8'h13;
    start = 1'b1;
    tick();
    da = 8'hFF;
    db = 8'h00;
    wait_done(8'h12, 8'h13);
    tick();
    start = 1'b0;
    wait_done(8'hFF, 8'h00);

    // Reset in the second compare cycle.
    tick();
    da = 8'h12;
    db = 8'h13;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk_idle_zero("abort");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_done", done, 0);
    end
    launch(8'h12, 8'h13);

    for (int n = 0; n < 200; n++) begin
      ra = DW'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra
         : (ra ^ DW'($urandom_range(0, 3) << (2 * $urandom_range(0, NS - 1))));
      if ($urandom_range(0, 2) == 0) tick();
      launch(ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_serial_controller.md
Name: comparator_serial_controller

Overview:
Multi-cycle magnitude comparator controller. Compares two DATA_WIDTH-bit unsigned operands 2 bits per cycle, MSB-first, by sequencing a single 2-bit comparator slice. Terminates early on the first unequal slice. Sits between a requesting datapath (Start/Done handshake) and the shared 2-bit compare resource.

Parameters:
DATA_WIDTH, 8, operand width in bits; must be even and >= 2; elaborate-time assertion otherwise.
NUM_SLICES, DATA_WIDTH/2, derived localparam; number of 2-bit slices.
CNT_WIDTH, $clog2(NUM_SLICES)+1, derived localparam; width of Compare_Count_Out.

Ports:
Clock_In  input  1  single clock; all state updates on rising edge.
Reset_In  input  1  synchronous, active-high reset.
Start_In  input  1  request a compare; sampled only when not busy.
Data_A_In  input  DATA_WIDTH  operand A, unsigned; captured on accepted Start.
Data_B_In  input  DATA_WIDTH  operand B, unsigned; captured on accepted Start.
Busy_Out  output  1  high while in COMPARE.
Done_Out  output  1  one-cycle pulse; results valid.
A_Less_Than_B_Out  output  1  registered result.
A_Equal_To_B_Out  output  1  registered result.
A_Greater_Than_B_Out  output  1  registered result.
Compare_Count_Out  output  CNT_WIDTH  number of slices evaluated for the last compare (1..NUM_SLICES).

Behaviour:
- One clock; reset is synchronous and active-high; ports Clock_In and Reset_In.
- Reset: state IDLE; Busy_Out=0, Done_Out=0, all three result outputs 0, Compare_Count_Out=0, operand registers 0, slice index 0.
- States: IDLE, COMPARE, DONE.
- IDLE: Start_In=1 -> capture both operands, index=NUM_SLICES-1, count=0 -> COMPARE. Start_In=0 -> stay.
- COMPARE: present slice [2*index+1 : 2*index] of both captured operands to the 2-bit comparator (combinational); count increments every cycle.
  - Slice unequal -> register LT/GT from slice, EQ=0 -> DONE.
  - Slice equal, index==0 -> register EQ=1, LT=GT=0 -> DONE.
  - Slice equal, index>0 -> index decrements, stay in COMPARE.
  - Start_In ignored; Data_*_In changes have no effect (operands already captured).
- DONE: Done_Out=1 for exactly this cycle. Start_In=1 -> accepted as in IDLE (back-to-back, no bubble). Otherwise -> IDLE.
- Latency: with k = slice number (1 = MSB slice) of first difference, or k=NUM_SLICES if equal, Done_Out is high in the cycle after the k-th edge following the edge that sampled Start_In. Compare_Count_Out=k.
- Results and Compare_Count_Out are held from DONE until the next accepted Start, then cleared to 0 on that edge. When valid, exactly one of LT/EQ/GT is high.
- Busy_Out=1 only in COMPARE; Done_Out and Busy_Out are never high together.
- Reset mid-COMPARE or in DONE aborts: all outputs return to reset values next edge, no Done_Out pulse.
- Comparator slice's own Reset_In is tied to the controller's Reset_In.

Decomposition:
- Shared package comparator_pkg: state enum (IDLE, COMPARE, DONE); 3-bit result encoding constants (LT=3'b100, EQ=3'b010, GT=3'b001).
- One sub-module: the existing Comparator_2_Bit is instantiated once as the slice datapath. The controller contains the FSM, operand registers, index and count.

Test Plan (DATA_WIDTH=8):
- Reset asserted 2 cycles, then released -> all outputs 0, Busy_Out=0, no Done_Out.
- A=8'h80, B=8'h40, Start 1 cycle -> Busy 1 cycle, then Done_Out with GT=1, Compare_Count_Out=1.
- A=8'h12, B=8'h13 -> Done after 4 compare cycles, LT=1, count=4. A=B=8'hB4 -> EQ=1, count=4.
- Start held high and operands changed during COMPARE -> ignored; result matches the captured operands; Start high in DONE cycle starts the next compare with no IDLE cycle.
- Reset asserted in 2nd COMPARE cycle of A=8'h12, B=8'h13 -> outputs zero next edge, no Done_Out; the following compare behaves normally.
- Randomized 200 compares vs. a reference model -> results and count match; exactly one result bit high at every Done_Out.
